// File: rtl/piso_pkg.sv
// Shared types and limits for the parallel-in / serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for the serializer; saturates at MAX and flags it.
module piso_bit_counter #(
    parameter int MAX = 7,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [CW-1:0] MaxCount = CW'(MAX);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != MaxCount)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == MaxCount);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with valid/ready load and a stallable serial side.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gWidthCheck
        $error("piso_serializer: WIDTH %0d outside legal range", WIDTH);
    end

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             isShift;
    logic             atLast;
    logic             accept;
    logic             wordDone;
    logic             advance;

    assign isShift  = (state_q == SHIFT);
    assign last     = isShift && atLast;
    // Ready on the final bit lets the next word follow with no idle bubble.
    assign load_ready = !isShift || (last && shift_en);
    assign accept   = load_valid && load_ready;
    assign wordDone = last && shift_en;
    assign advance  = isShift && shift_en && !atLast;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = parallel_in;
        end else if (wordDone) begin
            state_d = IDLE;
            shreg_d = '0;
        end else if (advance) begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    piso_bit_counter #(
        .MAX (WIDTH - 1),
        .CW  (CW)
    ) uBitCounter (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept || wordDone),
        .enable_i (advance),
        .tc_o     (atLast)
    );

    assign serial_valid = isShift;
    assign serial_out   = isShift ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: LSB-first and MSB-first 8-bit serializers share stimulus, plus a WIDTH=2 corner instance.
module tb_piso_serializer;

    typedef struct {
        logic b;
        logic l;
    } expBit_t;

    logic       clk;
    logic       rst;
    logic       loadValid;
    logic [7:0] parallelIn;
    logic       shiftEn;
    logic       readyL, outL, validL, lastL;
    logic       readyM, outM, validM, lastM;
    logic       lv2, se2;
    logic [1:0] pin2;
    logic       ready2, out2, valid2, last2;

    expBit_t qL[$];
    expBit_t qM[$];
    logic    predReady;
    int      compared;
    int      mismatched;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutL (
        .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(readyL),
        .parallel_in(parallelIn), .shift_en(shiftEn), .serial_out(outL),
        .serial_valid(validL), .last(lastL)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutM (
        .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(readyM),
        .parallel_in(parallelIn), .shift_en(shiftEn), .serial_out(outM),
        .serial_valid(validM), .last(lastM)
    );

    piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(ready2),
        .parallel_in(pin2), .shift_en(se2), .serial_out(out2),
        .serial_valid(valid2), .last(last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bit stream of a word, built from the bit-order rule alone.
    task automatic pushWord(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            qL.push_back('{b: w[i],     l: (i == 7)});
            qM.push_back('{b: w[7 - i], l: (i == 7)});
        end
    endtask

    // Drives one cycle from just after a rising edge to just after the next one.
    task automatic applyStimulus(input logic lv, input logic [7:0] word, input logic se);
        loadValid  = lv;
        parallelIn = word;
        shiftEn    = se;
        @(posedge clk);
        if (lv && predReady) pushWord(word);
        #1;
    endtask

    // Monitor: compares the DUT against the head of each queue on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic expReadyL;
            logic expReadyM;
            expReadyL = (qL.size() == 0) ? 1'b1 : (qL[0].l && shiftEn);
            expReadyM = (qM.size() == 0) ? 1'b1 : (qM[0].l && shiftEn);
            checkOutput("readyL", readyL, expReadyL);
            checkOutput("readyM", readyM, expReadyM);
            checkOutput("validL", validL, qL.size() != 0);
            checkOutput("validM", validM, qM.size() != 0);
            if (qL.size() != 0) begin
                checkOutput("bitL", outL, qL[0].b);
                checkOutput("lastL", lastL, qL[0].l);
                if (shiftEn) void'(qL.pop_front());
            end else begin
                checkOutput("idleOutL", {outL, lastL}, 2'b00);
            end
            if (qM.size() != 0) begin
                checkOutput("bitM", outM, qM[0].b);
                checkOutput("lastM", lastM, qM[0].l);
                if (shiftEn) void'(qM.pop_front());
            end else begin
                checkOutput("idleOutM", {outM, lastM}, 2'b00);
            end
            predReady = expReadyL;
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        predReady  = 1'b1;
        rst        = 1'b1;
        loadValid  = 1'b0;
        parallelIn = '0;
        shiftEn    = 1'b0;
        lv2        = 1'b0;
        pin2       = '0;
        se2        = 1'b1;

        // Reset state of every instance.
        #2;
        checkOutput("rstL", {outL, validL, lastL, readyL}, 4'b0001);
        checkOutput("rstM", {outM, validM, lastM, readyM}, 4'b0001);
        checkOutput("rst2", {out2, valid2, last2, ready2}, 4'b0001);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pattern 8'b11011010 in both bit orders, loaded on the first edge after reset.
        applyStimulus(1'b1, 8'hDA, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Back-to-back: 8'h3C held on load_valid until the last bit of 8'hA5.
        applyStimulus(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Three-cycle stall after bit 2 of 8'hF0.
        applyStimulus(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of 8'hFF.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midRstL", {outL, validL, lastL, readyL}, 4'b0001);
        checkOutput("midRstM", {outM, validM, lastM, readyM}, 4'b0001);
        qL.delete();
        qM.delete();
        predReady = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // Randomized traffic with random stalls and offers.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 40 && (qL.size() != 0 || qM.size() != 0); i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drainL", qL.size(), 0);
        checkOutput("drainM", qM.size(), 0);

        // WIDTH=2 corner: 2'b10 LSB first, with an offer while busy that must be ignored.
        lv2  = 1'b1;
        pin2 = 2'b10;
        @(posedge clk);
        #1;
        pin2 = 2'b11;
        @(negedge clk);
        checkOutput("w2bit0", {out2, valid2, last2, ready2}, 4'b0100);
        @(posedge clk);
        #1;
        lv2 = 1'b0;
        @(negedge clk);
        checkOutput("w2bit1", {out2, valid2, last2, ready2}, 4'b1111);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("w2idle", {out2, valid2, last2, ready2}, 4'b0001);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
